// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types plus the burst helpers used by the address-phase generator.
package ahb_pkg;
  typedef enum logic [1:0] {HT_IDLE, HT_BUSY, HT_NONSEQ, HT_SEQ} state_t;
  typedef enum logic [2:0] {B_SINGLE, B_INCR, B_WRAP4, B_INCR4,
                            B_WRAP8, B_INCR8, B_WRAP16, B_INCR16} burst_t;
  typedef enum logic [2:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD,
                            SZ_4WORD, SZ_8WORD, SZ_16WORD, SZ_32WORD} size_t;
  typedef enum logic {RESP_OKAY, RESP_ERROR} response_t;
  typedef enum logic {S_IDLE, S_BURST} gen_state_t;

  localparam int KB_BOUNDARY = 1024;
  localparam int KB_BITS     = $clog2(KB_BOUNDARY);

  function automatic logic [8:0] burst_beats(burst_t b, logic [7:0] len);
    case (b)
      B_SINGLE:          return 9'd1;
      B_INCR:            return {1'b0, len} + 9'd1;
      B_WRAP4, B_INCR4:  return 9'd4;
      B_WRAP8, B_INCR8:  return 9'd8;
      default:           return 9'd16;
    endcase
  endfunction

  function automatic logic is_wrap(burst_t b);
    return (b == B_WRAP4) || (b == B_WRAP8) || (b == B_WRAP16);
  endfunction
endpackage

// File: rtl/ahb_addr_next.sv
// Combinational next-beat address: linear increment, or wrap inside the (beats<<size) block.
module ahb_addr_next
  import ahb_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0] i_addr,
  input  logic [2:0]    i_size,
  input  logic [2:0]    i_burst,
  input  logic [8:0]    i_beats,
  output logic [AW-1:0] o_next_addr,
  output logic          o_kb_cross
);
  logic [AW-1:0] w_inc, w_mask, w_sum;
  logic          w_wrap;

  assign w_wrap      = is_wrap(burst_t'(i_burst));
  assign w_inc       = {{(AW-1){1'b0}}, 1'b1} << i_size;
  assign w_mask      = ({{(AW-9){1'b0}}, i_beats} << i_size) - {{(AW-1){1'b0}}, 1'b1};
  assign w_sum       = i_addr + w_inc;
  assign o_next_addr = w_wrap ? ((i_addr & ~w_mask) | (w_sum & w_mask)) : w_sum;
  // A wrap landing on a block base is not a boundary crossing.
  assign o_kb_cross  = !w_wrap && (o_next_addr[KB_BITS-1:0] == '0);
endmodule

// File: rtl/ahb_burst_gen.sv
// AHB-Lite master address-phase generator: one burst per request handshake,
// driving HTRANS/HADDR beat by beat with wait, BUSY, wrap, 1KB split and ERROR abort.
module ahb_burst_gen
  import ahb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic          req_write,
  input  logic [2:0]    req_burst,
  input  logic [2:0]    req_size,
  input  logic [7:0]    req_len,
  input  logic          hold,
  output logic [AW-1:0] HADDR,
  output logic [1:0]    HTRANS,
  output logic          HWRITE,
  output logic [2:0]    HSIZE,
  output logic [2:0]    HBURST,
  input  logic          HREADY,
  input  logic          HRESP,
  output logic          beat_acc,
  output logic          busy,
  output logic          err
);
  localparam logic [31:0] MAX_SIZE = 32'($clog2(DW / 8));

  gen_state_t    r_state;
  logic [8:0]    r_beats, r_left;
  logic [AW-1:0] w_next_addr;
  logic          w_kb_cross, w_beat, w_abort, w_legal;
  logic [1:0]    w_next_type, w_resume_type;

  ahb_addr_next #(.AW(AW)) u_addr_next (
    .i_addr      (HADDR),
    .i_size      (HSIZE),
    .i_burst     (HBURST),
    .i_beats     (r_beats),
    .o_next_addr (w_next_addr),
    .o_kb_cross  (w_kb_cross)
  );

  assign w_beat        = (HTRANS == HT_NONSEQ || HTRANS == HT_SEQ) && HREADY;
  assign w_abort       = (r_state == S_BURST) && (HRESP == RESP_ERROR) && !HREADY;
  assign w_legal       = {29'd0, req_size} <= MAX_SIZE;
  assign w_next_type   = (HBURST == B_INCR && w_kb_cross) ? HT_NONSEQ : HT_SEQ;
  // While BUSY, HADDR already holds the pending beat, so test that address itself.
  assign w_resume_type = (HBURST == B_INCR && HADDR[KB_BITS-1:0] == '0) ? HT_NONSEQ : HT_SEQ;
  assign beat_acc      = w_beat;
  assign busy          = (r_state == S_BURST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_beats   <= 9'd0;
      r_left    <= 9'd0;
      req_ready <= 1'b1;
      HADDR     <= '0;
      HTRANS    <= HT_IDLE;
      HWRITE    <= 1'b0;
      HSIZE     <= SZ_BYTE;
      HBURST    <= B_SINGLE;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            if (!w_legal) begin
              err <= 1'b1;
            end else begin
              r_state   <= S_BURST;
              req_ready <= 1'b0;
              r_beats   <= burst_beats(burst_t'(req_burst), req_len);
              r_left    <= burst_beats(burst_t'(req_burst), req_len) - 9'd1;
              HADDR     <= req_addr;
              HTRANS    <= HT_NONSEQ;
              HWRITE    <= req_write;
              HSIZE     <= req_size;
              HBURST    <= req_burst;
            end
          end
        end
        S_BURST: begin
          if (w_abort) begin
            r_state   <= S_IDLE;
            req_ready <= 1'b1;
            HTRANS    <= HT_IDLE;
            err       <= 1'b1;
          end else if (w_beat) begin
            if (r_left == 9'd0) begin
              r_state   <= S_IDLE;
              req_ready <= 1'b1;
              HTRANS    <= HT_IDLE;
            end else begin
              r_left <= r_left - 9'd1;
              HADDR  <= w_next_addr;
              HTRANS <= hold ? HT_BUSY : w_next_type;
            end
          end else if (HREADY && !hold) begin
            HTRANS <= w_resume_type;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  a_fixed_incr_no_1kb: assert property (@(posedge clk) disable iff (rst)
    !(w_beat && r_left != 9'd0 && w_kb_cross &&
      (HBURST == B_INCR4 || HBURST == B_INCR8 || HBURST == B_INCR16)));
endmodule

// File: tb/tb_ahb_burst_gen.sv
// Bench for ahb_burst_gen: directed scenarios plus random bursts checked cycle by cycle
// against a beat list derived from plain address arithmetic.
module tb_ahb_burst_gen;
  import ahb_pkg::*;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0, rst = 1'b1;
  logic          req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [2:0]    req_burst = '0, req_size = '0;
  logic [7:0]    req_len = '0;
  logic          hold = 1'b0;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE, HBURST;
  logic          HREADY = 1'b1, HRESP = 1'b0;
  logic          beat_acc, busy, err;

  int checks = 0, failures = 0, cyc = 0;
  logic [31:0] obs_addr[$];
  int obs_ns, obs_busy, first_ns_cyc, last_acc_cyc;
  logic [31:0] obs_busy_addr;

  ahb_burst_gen #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_write(req_write), .req_burst(req_burst),
    .req_size(req_size), .req_len(req_len), .hold(hold),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HREADY(HREADY), .HRESP(HRESP), .beat_acc(beat_acc), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int n_beats(input logic [2:0] b, input logic [7:0] l);
    case (b)
      B_SINGLE:         return 1;
      B_INCR:           return int'(l) + 1;
      B_WRAP4, B_INCR4: return 4;
      B_WRAP8, B_INCR8: return 8;
      default:          return 16;
    endcase
  endfunction

  // Runs one burst starting just after a negedge; returns just after a negedge in an IDLE cycle.
  task automatic run_burst(input logic [31:0] a, input logic w, input logic [2:0] b,
                           input logic [2:0] s, input logic [7:0] l,
                           input int hold_pct, input int wait_pct,
                           input int hb, input int hn, input int wb, input int wn, input int eb);
    logic [31:0] ea[$];
    logic [1:0]  et[$];
    logic [31:0] ad, exp_a;
    logic [1:0]  exp_t;
    logic        exp_err, hr, hd, he, xfer, exp_beat;
    int unsigned sz, blk;
    int n, k, acc, h_left, w_left, guard;
    bit h_f, w_f, e_f, aborted;
    n = n_beats(b, l); sz = 32'd1 << s; blk = 32'(n) * sz;
    for (int i = 0; i < n; i++) begin
      if (b == B_WRAP4 || b == B_WRAP8 || b == B_WRAP16)
        ad = a - (a % blk) + ((a % blk + 32'(i) * sz) % blk);
      else
        ad = a + 32'(i) * sz;
      ea.push_back(ad);
      et.push_back((i == 0 || (b == B_INCR && ad % 1024 == 0)) ? HT_NONSEQ : HT_SEQ);
    end
    obs_addr.delete(); obs_ns = 0; obs_busy = 0; obs_busy_addr = '0;
    req_valid = 1'b1; req_addr = a; req_write = w; req_burst = b; req_size = s; req_len = l;
    HREADY = 1'b1; hold = 1'b0; HRESP = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL req_ready_idle: got %b want 1", req_ready);
    end
    @(posedge clk); #1 req_valid = 1'b0;
    exp_t = HT_NONSEQ; exp_a = ea[0]; exp_err = 1'b0;
    k = 0; acc = 0; h_left = 0; w_left = 0; guard = 0;
    h_f = 0; w_f = 0; e_f = 0; aborted = 0; first_ns_cyc = -1;
    forever begin
      @(negedge clk);
      hr = 1'b1; hd = 1'b0; he = aborted;
      xfer = (exp_t == HT_NONSEQ || exp_t == HT_SEQ);
      if (eb > 0 && !e_f && xfer && k == eb - 1) begin
        hr = 1'b0; he = 1'b1; e_f = 1;
      end else if (exp_t != HT_IDLE) begin
        if (hb > 0 && !h_f && xfer && k == hb - 2) begin h_left = hn; h_f = 1; end
        if (wb > 0 && !w_f && xfer && k == wb - 1) begin w_left = wn; w_f = 1; end
        if (h_left > 0) begin hd = 1'b1; h_left--; end
        else hd = ($urandom_range(0, 99) < hold_pct);
        if (w_left > 0) begin hr = 1'b0; w_left--; end
        else hr = !($urandom_range(0, 99) < wait_pct);
      end
      HREADY = hr; hold = hd; HRESP = he;
      #1;
      exp_beat = xfer && hr;
      if (first_ns_cyc < 0) first_ns_cyc = cyc;
      checks++;
      if (HTRANS !== exp_t || (exp_t != HT_IDLE && HADDR !== exp_a)) begin
        failures++;
        $display("FAIL htrans_haddr cyc=%0d: got %0d@%h want %0d@%h", cyc, HTRANS, HADDR, exp_t, exp_a);
      end
      if (exp_t != HT_IDLE) begin
        checks++;
        if (HBURST !== b || HSIZE !== s || HWRITE !== w) begin
          failures++;
          $display("FAIL ctrl cyc=%0d: got b%0d s%0d w%b want b%0d s%0d w%b", cyc, HBURST, HSIZE, HWRITE, b, s, w);
        end
      end
      checks++;
      if (beat_acc !== exp_beat) begin
        failures++; $display("FAIL beat_acc cyc=%0d: got %b want %b", cyc, beat_acc, exp_beat);
      end
      checks++;
      if (busy !== (exp_t != HT_IDLE) || req_ready !== (exp_t == HT_IDLE) || err !== exp_err) begin
        failures++;
        $display("FAIL status cyc=%0d: got busy%b rdy%b err%b want busy%b rdy%b err%b", cyc,
                 busy, req_ready, err, exp_t != HT_IDLE, exp_t == HT_IDLE, exp_err);
      end
      if (beat_acc) begin
        acc++; obs_addr.push_back(HADDR); last_acc_cyc = cyc;
        if (HTRANS == HT_NONSEQ) obs_ns++;
      end
      if (HTRANS == HT_BUSY) begin obs_busy++; obs_busy_addr = HADDR; end
      if (exp_t == HT_IDLE) break;
      if (he) begin
        exp_t = HT_IDLE; exp_err = 1'b1; aborted = 1;
      end else if (hr) begin
        if (exp_t != HT_BUSY) begin
          k++;
          if (k == n) exp_t = HT_IDLE;
          else begin exp_a = ea[k]; exp_t = hd ? HT_BUSY : et[k]; end
        end else begin
          exp_t = hd ? HT_BUSY : et[k];
        end
      end
      guard++;
      if (guard > 4000) begin
        failures++; $display("FAIL timeout: burst did not finish within 4000 cycles");
        break;
      end
    end
    if (aborted) begin
      @(negedge clk); HRESP = 1'b0; HREADY = 1'b1; #1;
      checks++;
      if (err !== 1'b0 || req_ready !== 1'b1 || HTRANS !== HT_IDLE) begin
        failures++; $display("FAIL err_after: got err%b rdy%b ht%0d want 0 1 0", err, req_ready, HTRANS);
      end
    end
    hold = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
    checks++;
    if (acc !== (aborted ? eb - 1 : n)) begin
      failures++; $display("FAIL beat_count: got %0d want %0d", acc, aborted ? eb - 1 : n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (HTRANS !== HT_IDLE || HADDR !== '0 || HWRITE !== 1'b0) begin
      failures++; $display("FAIL reset_ahb: got ht%0d a%h w%b want 0 0 0", HTRANS, HADDR, HWRITE);
    end
    checks++;
    if (HSIZE !== SZ_BYTE || HBURST !== B_SINGLE) begin
      failures++; $display("FAIL reset_ctrl: got s%0d b%0d want 0 0", HSIZE, HBURST);
    end
    checks++;
    if (req_ready !== 1'b1 || beat_acc !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      failures++; $display("FAIL reset_status: got rdy%b acc%b busy%b err%b want 1 0 0 0", req_ready, beat_acc, busy, err);
    end
    rst = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic test_incr4();
    logic [31:0] ex[4];
    ex = '{32'h100, 32'h104, 32'h108, 32'h10C};
    run_burst(32'h100, 1'b1, B_INCR4, SZ_WORD, 8'd0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs_addr.size() != 4) begin
      failures++; $display("FAIL incr4_len: got %0d want 4", obs_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_addr[i] !== ex[i]) begin
          failures++; $display("FAIL incr4_addr%0d: got %h want %h", i, obs_addr[i], ex[i]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] ex4[4];
    logic [31:0] ex8[8];
    ex4 = '{32'h38, 32'h3C, 32'h30, 32'h34};
    ex8 = '{32'h0E, 32'h00, 32'h02, 32'h04, 32'h06, 32'h08, 32'h0A, 32'h0C};
    run_burst(32'h38, 1'b0, B_WRAP4, SZ_WORD, 8'd0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4 && i < obs_addr.size(); i++) begin
      checks++;
      if (obs_addr[i] !== ex4[i]) begin
        failures++; $display("FAIL wrap4_addr%0d: got %h want %h", i, obs_addr[i], ex4[i]);
      end
    end
    run_burst(32'h0E, 1'b1, B_WRAP8, SZ_HALF, 8'd0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8 && i < obs_addr.size(); i++) begin
      checks++;
      if (obs_addr[i] !== ex8[i]) begin
        failures++; $display("FAIL wrap8_addr%0d: got %h want %h", i, obs_addr[i], ex8[i]);
      end
    end
  endtask

  task automatic test_kb_split();
    run_burst(32'h3F8, 1'b0, B_INCR, SZ_WORD, 8'd7, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs_ns !== 2 || obs_addr.size() != 8 || obs_addr[2] !== 32'h400) begin
      failures++; $display("FAIL kb_split: got ns=%0d beats=%0d want ns=2 beats=8 third=400", obs_ns, obs_addr.size());
    end
  endtask

  task automatic test_hold_wait();
    run_burst(32'h200, 1'b1, B_INCR8, SZ_WORD, 8'd0, 0, 0, 3, 2, 5, 3, 0);
    checks++;
    if (obs_busy !== 2 || obs_busy_addr !== 32'h208) begin
      failures++; $display("FAIL hold_busy: got %0d@%h want 2@00000208", obs_busy, obs_busy_addr);
    end
  endtask

  task automatic test_error();
    run_burst(32'h40, 1'b0, B_INCR16, SZ_WORD, 8'd0, 0, 0, 0, 0, 0, 0, 6);
  endtask

  task automatic test_back_to_back();
    int l1;
    run_burst(32'h500, 1'b1, B_INCR4, SZ_HALF, 8'd0, 0, 0, 0, 0, 0, 0, 0);
    l1 = last_acc_cyc;
    run_burst(32'h600, 1'b0, B_SINGLE, SZ_BYTE, 8'd0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (first_ns_cyc - l1 != 2) begin
      failures++; $display("FAIL b2b_gap: got %0d want 2", first_ns_cyc - l1);
    end
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_addr = 32'h800; req_burst = B_INCR8; req_size = SZ_WORD; req_write = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (HTRANS !== HT_IDLE || busy !== 1'b0 || req_ready !== 1'b1 || beat_acc !== 1'b0) begin
      failures++; $display("FAIL reset_mid: got ht%0d busy%b rdy%b acc%b want 0 0 1 0", HTRANS, busy, req_ready, beat_acc);
    end
    @(negedge clk); rst = 1'b0; #1;
  endtask

  task automatic test_illegal_size();
    req_valid = 1'b1; req_addr = 32'h10; req_burst = B_INCR4; req_size = SZ_DWORD;
    #1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (err !== 1'b1 || HTRANS !== HT_IDLE || busy !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL illegal_err: got err%b ht%0d busy%b rdy%b want 1 0 0 1", err, HTRANS, busy, req_ready);
    end
    @(negedge clk); #1;
    checks++;
    if (err !== 1'b0 || HTRANS !== HT_IDLE) begin
      failures++; $display("FAIL illegal_after: got err%b ht%0d want 0 0", err, HTRANS);
    end
  endtask

  task automatic test_random();
    logic [2:0]  b, s;
    logic [7:0]  l;
    logic [31:0] a;
    int unsigned sz;
    int n;
    for (int t = 0; t < 30; t++) begin
      b = 3'($urandom_range(0, 7)); s = 3'($urandom_range(0, 2)); l = 8'($urandom_range(0, 127));
      n = n_beats(b, l); sz = 32'd1 << s;
      if (b == B_INCR || b == B_WRAP4 || b == B_WRAP8 || b == B_WRAP16)
        a = ($urandom & 32'h00FF_FFFF) & ~(sz - 1);
      else
        a = ($urandom & 32'h00FF_FC00) | ($urandom_range(0, 1024 / sz - n) * sz);
      run_burst(a, 1'($urandom), b, s, l, 20, 20, 0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_incr4();
    test_wrap();
    test_kb_split();
    test_hold_wait();
    test_error();
    test_back_to_back();
    test_illegal_size();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
